// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: WIDTH-bit word in over valid/ready, one bit per clock out.
// Define BITSER_LSB_FIRST_EN for LSB-first order; default build is MSB-first.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             x_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             x_last_q, x_last_d;
  logic             busy_q, busy_d;
  logic             xfer_s;
  logic             at_last_s;

`ifdef BITSER_LSB_FIRST_EN
  function automatic logic first_bit(input logic [WIDTH-1:0] s);
    return s[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    return {1'b0, s[WIDTH-1:1]};
  endfunction
`else
  function automatic logic first_bit(input logic [WIDTH-1:0] s);
    return s[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], 1'b0};
  endfunction
`endif

  // Ready depends only on state and counter so upstream may wait on it.
  assign at_last_s = (state_q == SHIFT) && (cnt_q == LAST);
  assign din_ready = (state_q == IDLE) || at_last_s;
  assign xfer_s    = din_valid && din_ready;

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          state_d = SHIFT;
          sreg_d  = din;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          if (xfer_s) begin
            sreg_d = din;
            cnt_d  = {CW{1'b0}};
          end else begin
            state_d = IDLE;
            sreg_d  = advance(sreg_q);
            cnt_d   = {CW{1'b0}};
          end
        end else begin
          sreg_d = advance(sreg_q);
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sreg_d  = {WIDTH{1'b0}};
        cnt_d   = {CW{1'b0}};
      end
    endcase

    // Outputs describe the bit that will be on the wire after the edge.
    x_valid_d = (state_d == SHIFT);
    busy_d    = x_valid_d;
    x_out_d   = x_valid_d ? first_bit(sreg_d) : 1'b0;
    x_last_d  = x_valid_d && (cnt_d == LAST);
  end

  // State and registered outputs; reset wins over a simultaneous transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= {WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      x_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      x_last_q  <= x_last_d;
      busy_q    <= busy_d;
    end
  end

  assign x_out   = x_out_q;
  assign x_valid = x_valid_q;
  assign x_last  = x_last_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer (WIDTH=8): vector table, directed multi-cycle sequences,
// and random traffic against a queue-based model of the emitted bit stream.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready, x_out, x_valid, x_last, busy;

  int total = 0;
  int bad   = 0;

  // Model: queue of bits still to appear on x_out; the head is the bit on the wire.
  logic mq[$];
  logic m_xfer;
  logic pre_ready;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       xo, xv, xl, bz, rdy;
  } vec_t;

  vec_t tv[9];

  bit_serializer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .x_out(x_out), .x_valid(x_valid), .x_last(x_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
`ifdef BITSER_LSB_FIRST_EN
    for (int b = 0; b < 8; b++) mq.push_back(d[b]);
`else
    for (int b = 7; b >= 0; b--) mq.push_back(d[b]);
`endif
  endtask

  // One clock: drive, check ready, advance model at the edge, check outputs.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    logic exp_rdy;
    rst = r; din_valid = v; din = d;
    #1;
    exp_rdy   = (mq.size() <= 1);
    pre_ready = din_ready;
    check("din_ready", din_ready, exp_rdy);
    @(posedge clk);
    m_xfer = !r && v && exp_rdy;
    if (r) mq.delete();
    else begin
      if (mq.size() > 0) void'(mq.pop_front());
      if (m_xfer) push_word(d);
    end
    #1;
    check("x_valid", x_valid, mq.size() > 0);
    check("x_out", x_out, (mq.size() > 0) ? mq[0] : 1'b0);
    check("x_last", x_last, mq.size() == 1);
    check("busy", busy, mq.size() > 0);
  endtask

  // Stream nw left-aligned words with valid held until all are taken.
  task automatic burst(input int nw, input logic [31:0] words, output logic [31:0] st,
                       output logic [31:0] lm, output int vcnt, output int rcnt);
    logic [31:0] pend;
    int sent;
    pend = words; sent = 0; st = '0; lm = '0; vcnt = 0; rcnt = 0;
    for (int i = 0; i < nw * 8; i++) begin
      step(1'b0, sent < nw, pend[31:24]);
      if (pre_ready) rcnt++;
      if (m_xfer) begin sent++; pend = pend << 8; end
      st = {st[30:0], x_out};
      lm = {lm[30:0], x_last};
      if (x_valid) vcnt++;
    end
  endtask

  initial begin
    logic [7:0]  exp96;
    logic [31:0] st, lm, dm;
    int          vcnt, rcnt;

`ifdef BITSER_LSB_FIRST_EN
    exp96 = 8'b0110_1001;
`else
    exp96 = 8'b1001_0110;
`endif
    tv[0] = '{1'b1, 8'h96, exp96[7], 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 1; i < 8; i++)
      tv[i] = '{1'b0, 8'h00, exp96[7-i], 1'b1, (i == 7), 1'b1, (i == 7)};
    tv[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_x_valid", x_valid, 1'b0);
    check("rst_x_out", x_out, 1'b0);
    check("rst_x_last", x_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_din_ready", din_ready, 1'b1);

    // Single word 8'h96 from the table
    for (int i = 0; i < 9; i++) begin
      step(1'b0, tv[i].v, tv[i].d);
      check("tv_x_out", x_out, tv[i].xo);
      check("tv_x_valid", x_valid, tv[i].xv);
      check("tv_x_last", x_last, tv[i].xl);
      check("tv_busy", busy, tv[i].bz);
      check("tv_din_ready", din_ready, tv[i].rdy);
    end

    // Back-to-back 8'h90, 8'h09 feeding a 1001 detector
    burst(2, 32'h9009_0000, st, lm, vcnt, rcnt);
    dm = '0;
    for (int k = 4; k <= 16; k++)
      if (st[(19-k) -: 4] == 4'b1001) dm[k-1] = 1'b1;
`ifdef BITSER_LSB_FIRST_EN
    check32("b2b_stream", st, 32'h0000_0990);
    check32("b2b_detect", dm, 32'h0000_0880);
`else
    check32("b2b_stream", st, 32'h0000_9009);
    check32("b2b_detect", dm, 32'h0000_8008);
`endif
    check32("b2b_last", lm, 32'h0000_0101);
    check32("b2b_valid_cnt", vcnt, 32'd16);
    check32("b2b_ready_cnt", rcnt, 32'd2);
    step(1'b0, 1'b0, 8'h00);
    check("b2b_idle", x_valid, 1'b0);

    // Cross-boundary 8'h01, 8'h00, 8'h80
    burst(3, 32'h0100_8000, st, lm, vcnt, rcnt);
`ifdef BITSER_LSB_FIRST_EN
    check32("xb_stream", st, 32'h0080_0001);
`else
    check32("xb_stream", st, 32'h0001_0080);
`endif
    check32("xb_last", lm, 32'h0001_0101);
    check32("xb_valid_cnt", vcnt, 32'd24);
    check32("xb_ready_cnt", rcnt, 32'd3);
    step(1'b0, 1'b0, 8'h00);

    // din_valid with 8'hFF mid-word is ignored
    st = '0;
    step(1'b0, 1'b1, 8'h3C); st = {st[30:0], x_out};
    step(1'b0, 1'b0, 8'h00); st = {st[30:0], x_out};
    step(1'b0, 1'b0, 8'h00); st = {st[30:0], x_out};
    step(1'b0, 1'b1, 8'hFF); st = {st[30:0], x_out};
    check("ign_ready", pre_ready, 1'b0);
    check("ign_xfer", m_xfer, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h00); st = {st[30:0], x_out};
    end
    check32("ign_stream", st, 32'h0000_003C);
    step(1'b0, 1'b0, 8'h00);
    check("ign_idle", x_valid, 1'b0);

    // Reset at the 4th bit of 8'hA5 with din_valid high
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    check("mid_busy_before", busy, 1'b1);
    step(1'b1, 1'b1, 8'h5A);
    check("mid_x_valid", x_valid, 1'b0);
    check("mid_x_out", x_out, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_din_ready", din_ready, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    check("mid_no_replay", x_valid, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, 8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
